load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 21 ++
 rtl/lsu_align.sv | 85 ++++++++
 rtl/load_store_unit.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 size/sign codes
// and the controller state encoding.
package lsu_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        WB     = 2'b10,
        ERR    = 2'b11
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic: store enables/replication, load lane select/extension, request legality.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned halfword/word requests become illegal.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [1:0]  req_off,
    input  logic [31:0] req_wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic        illegal,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic        bad_f3_s;
    logic        misalign_s;
    logic [7:0]  ld_byte_s;
    logic [15:0] ld_half_s;

    // Store byte enables and lane replication; loads always read the whole word.
    always_comb begin
        be         = 4'b1111;
        wdata_lane = 32'h0000_0000;
        if (req_we) begin
            case (req_funct3)
                SB: begin
                    be         = 4'b0001 << req_off;
                    wdata_lane = {4{req_wdata[7:0]}};
                end
                SH: begin
                    be         = req_off[1] ? 4'b1100 : 4'b0011;
                    wdata_lane = {2{req_wdata[15:0]}};
                end
                default: begin
                    be         = 4'b1111;
                    wdata_lane = req_wdata;
                end
            endcase
        end else begin
            be         = 4'b1111;
            wdata_lane = 32'h0000_0000;
        end
    end

    // Request legality: unsupported funct3 codes, plus misalignment when trapping is built in.
    always_comb begin
        misalign_s = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        case (req_funct3[1:0])
            2'b01:   misalign_s = req_off[0];
            2'b10:   misalign_s = (req_off != 2'b00);
            default: misalign_s = 1'b0;
        endcase
`endif
        if (req_we) begin
            bad_f3_s = (req_funct3 != SB) && (req_funct3 != SH) && (req_funct3 != SW);
        end else begin
            bad_f3_s = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111);
        end
        illegal = bad_f3_s | misalign_s;
    end

    // Load lane select and sign/zero extension of the returned word.
    always_comb begin
        case (ld_off)
            2'b00:   ld_byte_s = ld_rdata[7:0];
            2'b01:   ld_byte_s = ld_rdata[15:8];
            2'b10:   ld_byte_s = ld_rdata[23:16];
            default: ld_byte_s = ld_rdata[31:24];
        endcase
        ld_half_s = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        case (ld_funct3)
            LB:      ld_data = {{24{ld_byte_s[7]}}, ld_byte_s};
            LH:      ld_data = {{16{ld_half_s[15]}}, ld_half_s};
            LBU:     ld_data = {24'h00_0000, ld_byte_s};
            LHU:     ld_data = {16'h0000, ld_half_s};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding access, ack timeout, one-cycle writeback.
// Misaligned-access trapping is selected by LSU_MISALIGN_TRAP_EN inside lsu_align.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [2:0]                req_funct3,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [31:0]               req_wdata,
    input  logic [REG_ADDR_WIDTH-1:0] req_rd,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [3:0]                mem_be,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [31:0]               mem_wdata,
    input  logic [31:0]               mem_rdata,
    input  logic                      mem_ack,
    output logic                      wb_we3,
    output logic [REG_ADDR_WIDTH-1:0] wb_ad3,
    output logic [31:0]               wb_wd3,
    output logic                      busy,
    output logic                      err
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    lsu_state_e                state_r, state_nxt_s;
    logic [CNT_W-1:0]          cnt_r;
    logic                      we_r;
    logic [2:0]                funct3_r;
    logic [1:0]                off_r;
    logic [REG_ADDR_WIDTH-1:0] rd_r;
    logic [3:0]                be_s;
    logic [31:0]               wdata_lane_s;
    logic                      illegal_s;
    logic [31:0]               ld_data_s;

    lsu_align u_align (
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_off    (req_addr[1:0]),
        .req_wdata  (req_wdata),
        .be         (be_s),
        .wdata_lane (wdata_lane_s),
        .illegal    (illegal_s),
        .ld_funct3  (funct3_r),
        .ld_off     (off_r),
        .ld_rdata   (mem_rdata),
        .ld_data    (ld_data_s)
    );

    // Next-state logic; ack is tested before the timeout so it wins a tie.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    state_nxt_s = illegal_s ? ERR : ACCESS;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    state_nxt_s = we_r ? IDLE : WB;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ERR;
                end else begin
                    state_nxt_s = ACCESS;
                end
            end
            WB:      state_nxt_s = IDLE;
            ERR:     state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, request capture and all outputs, registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            we_r      <= 1'b0;
            funct3_r  <= 3'b000;
            off_r     <= 2'b00;
            rd_r      <= '0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            err       <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'b0000;
            mem_addr  <= '0;
            mem_wdata <= 32'h0000_0000;
            wb_we3    <= 1'b0;
            wb_ad3    <= '0;
            wb_wd3    <= 32'h0000_0000;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= (state_r == ACCESS) ? (cnt_r + CNT_ONE) : '0;
            req_ready <= (state_nxt_s == IDLE);
            busy      <= (state_nxt_s != IDLE);
            err       <= (state_nxt_s == ERR);
            mem_en    <= (state_nxt_s == ACCESS);
            if ((state_r == IDLE) && req_valid) begin
                we_r     <= req_we;
                funct3_r <= req_funct3;
                off_r    <= req_addr[1:0];
                rd_r     <= req_rd;
            end
            // Memory-side fields are loaded once on entry and held for the whole access.
            if ((state_r == IDLE) && (state_nxt_s == ACCESS)) begin
                mem_we    <= req_we;
                mem_be    <= be_s;
                mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                mem_wdata <= wdata_lane_s;
            end else if (state_nxt_s != ACCESS) begin
                mem_we    <= 1'b0;
                mem_be    <= 4'b0000;
                mem_addr  <= '0;
                mem_wdata <= 32'h0000_0000;
            end
            if (state_nxt_s == WB) begin
                wb_we3 <= (rd_r != '0);
                wb_ad3 <= rd_r;
                wb_wd3 <= ld_data_s;
            end else begin
                wb_we3 <= 1'b0;
                wb_ad3 <= '0;
                wb_wd3 <= 32'h0000_0000;
            end
        end
    end

endmodule
